mdu_seq: RTL

Parametrised sequential multiply/divide unit for the MIPS execute stage. It is the successor to the single-cycle combinational multiplier. It adds signed and unsigned multiply, signed and unsigned divide, HI/LO result registers, and a start/busy/done handshake. It uses one shared iterative datapath that retires one bit per cycle, so a 64-bit product no longer sits on the critical path.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings as seen on the op port and the control state encoding.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit for the execute stage. One bit is retired
// per cycle on a shared 2*WIDTH shift register and a single WIDTH+1 bit
// adder/subtractor. Signed operations run on magnitudes and the sign is
// restored when HI/LO are written.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic               op_mul;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;

  logic               req_mul;
  logic               req_signed;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_r;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Decode the incoming request and reduce signed operands to magnitudes
  always_comb begin
    req_mul    = 1'b0;
    req_signed = 1'b0;
    case (op)
      MDU_MULTU: begin req_mul = 1'b1; req_signed = 1'b0; end
      MDU_MULT:  begin req_mul = 1'b1; req_signed = 1'b1; end
      MDU_DIVU:  begin req_mul = 1'b0; req_signed = 1'b0; end
      MDU_DIV:   begin req_mul = 1'b0; req_signed = 1'b1; end
      default:   begin req_mul = 1'b0; req_signed = 1'b0; end
    endcase
    a_mag_in = (req_signed && a[WIDTH-1]) ? -a : a;
    b_mag_in = (req_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide,
  // both through the same adder (subtract = add of the inverted divisor + 1)
  always_comb begin
    acc_hi = acc[2*WIDTH-1:WIDTH];
    add_x  = op_mul ? {1'b0, acc_hi} : {acc_hi, acc[WIDTH-1]};
    add_y  = op_mul ? {1'b0, b_mag} : ~{1'b0, b_mag};
    add_r  = add_x + add_y + (WIDTH+1)'(!op_mul);
    if (op_mul) begin
      acc_step = acc[0] ? {add_r, acc[WIDTH-1:1]} : {1'b0, acc_hi, acc[WIDTH-1:1]};
    end else begin
      acc_step = add_r[WIDTH] ? {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {add_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign restoration; a zero divisor leaves the all-ones quotient untouched
  // and the remainder, which then equals |a|, turns back into a
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = ((sign_a ^ sign_b) && (b_mag != '0)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc_hi : acc_hi;
  end

  // Control FSM with registered busy/done and the HI/LO result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_mul <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            op_mul <= req_mul;
            sign_a <= req_signed & a[WIDTH-1];
            sign_b <= req_signed & b[WIDTH-1];
            b_mag  <= b_mag_in;
            acc    <= {{WIDTH{1'b0}}, a_mag_in};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST_ITER) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (op_mul) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
